// File: rtl/tmds_video_timing.sv
// rtl/tmds_video_timing.sv - decoded TMDS words to pixels, coordinates, frame geometry and timing lock
module tmds_video_timing #(
  parameter int   COORD_BITS   = 12,
  parameter int   MIN_RUN      = 16,
  parameter logic VSYNC_POL    = 1'b1,
  parameter int   LOCK_FRAMES  = 3,
  parameter int   TIMEOUT_BITS = 24
) (
  input  logic                  hdmi_clk,
  input  logic                  reset,
  input  logic                  data_valid,
  input  logic                  sync_valid,
  input  logic [1:0]            sync,
  input  logic [7:0]            d0,
  input  logic [7:0]            d1,
  input  logic [7:0]            d2,
  output logic                  pixel_valid,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  output logic [COORD_BITS-1:0] x,
  output logic [COORD_BITS-1:0] y,
  output logic                  frame_start,
  output logic                  line_start,
  output logic [COORD_BITS-1:0] width,
  output logic [COORD_BITS-1:0] height,
  output logic                  locked
);

  localparam int SW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [COORD_BITS-1:0] MIN_RUN_C = COORD_BITS'(MIN_RUN);
  localparam logic [COORD_BITS-1:0] ONE_C     = COORD_BITS'(1);
  localparam logic [SW-1:0]         LOCK_C    = SW'(LOCK_FRAMES);
  localparam logic [SW-1:0]         SONE_C    = SW'(1);
  localparam logic [TIMEOUT_BITS:0] TONE_C    = (TIMEOUT_BITS+1)'(1);

  typedef enum logic {BLANK = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                state_q;
  logic                  vsync_hold_q;
  logic                  vsync_pending_q;
  logic                  irregular_q;
  logic                  have_line_q;
  logic [COORD_BITS-1:0] line_count_q;
  logic [COORD_BITS-1:0] run_len_q;
  logic [COORD_BITS-1:0] frame_width_q;
  logic [COORD_BITS-1:0] prev_width_q;
  logic [COORD_BITS-1:0] prev_height_q;
  logic [SW-1:0]         stable_count_q;
  logic [TIMEOUT_BITS:0] timeout_q;

  logic                  pixel_valid_q;
  logic [7:0]            r_q, g_q, b_q;
  logic [COORD_BITS-1:0] x_q, y_q, width_q, height_q;
  logic                  frame_start_q, line_start_q, locked_q;

  logic                  vsync_edge;
  logic                  commit;
  logic [COORD_BITS-1:0] line_count_d;
  logic [COORD_BITS-1:0] frame_width_d;
  logic                  irregular_d;
  logic                  frame_ok;
  logic [SW-1:0]         stable_count_d;

  // hsync carries no information here; runs are delimited by data_valid alone
  logic unused_hsync;
  assign unused_hsync = sync[0];

  // Line commit happens before the vsync evaluation so a run ending on the edge cycle counts in this frame
  always_comb begin
    vsync_edge     = sync_valid && (vsync_hold_q != VSYNC_POL) && (sync[1] == VSYNC_POL);
    commit         = (state_q == ACTIVE) && !data_valid && (run_len_q >= MIN_RUN_C);
    line_count_d   = commit ? (y_q + ONE_C) : line_count_q;
    frame_width_d  = (commit && !have_line_q) ? run_len_q : frame_width_q;
    irregular_d    = irregular_q || (commit && have_line_q && (run_len_q != frame_width_q));
    frame_ok       = !irregular_d && (line_count_d != '0) &&
                     (line_count_d == prev_height_q) && (frame_width_d == prev_width_q);
    stable_count_d = '0;
    if (frame_ok) begin
      stable_count_d = (stable_count_q == LOCK_C) ? stable_count_q : (stable_count_q + SONE_C);
    end
  end

  // Run tracking FSM, line/frame bookkeeping, lock qualification and timeout
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      state_q         <= BLANK;
      vsync_hold_q    <= !VSYNC_POL;
      vsync_pending_q <= 1'b0;
      irregular_q     <= 1'b0;
      have_line_q     <= 1'b0;
      line_count_q    <= '0;
      run_len_q       <= '0;
      frame_width_q   <= '0;
      prev_width_q    <= '0;
      prev_height_q   <= '0;
      stable_count_q  <= '0;
      timeout_q       <= '0;
      pixel_valid_q   <= 1'b0;
      r_q             <= '0;
      g_q             <= '0;
      b_q             <= '0;
      x_q             <= '0;
      y_q             <= '0;
      width_q         <= '0;
      height_q        <= '0;
      frame_start_q   <= 1'b0;
      line_start_q    <= 1'b0;
      locked_q        <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;

      if (sync_valid) begin
        vsync_hold_q <= sync[1];
      end

      case (state_q)
        BLANK: begin
          if (data_valid) begin
            state_q       <= ACTIVE;
            pixel_valid_q <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= vsync_pending_q;
            x_q           <= '0;
            y_q           <= vsync_pending_q ? '0 : line_count_q;
            run_len_q     <= ONE_C;
            r_q           <= d2;
            g_q           <= d1;
            b_q           <= d0;
          end
        end
        ACTIVE: begin
          if (data_valid) begin
            pixel_valid_q <= 1'b1;
            x_q           <= (x_q == '1) ? x_q : (x_q + ONE_C);
            run_len_q     <= (run_len_q == '1) ? run_len_q : (run_len_q + ONE_C);
            r_q           <= d2;
            g_q           <= d1;
            b_q           <= d0;
          end else begin
            state_q <= BLANK;
          end
        end
        default: state_q <= BLANK;
      endcase

      line_count_q  <= line_count_d;
      frame_width_q <= frame_width_d;
      irregular_q   <= irregular_d;
      if (commit) begin
        width_q         <= run_len_q;
        vsync_pending_q <= 1'b0;
        have_line_q     <= 1'b1;
      end

      if (vsync_edge) begin
        height_q        <= line_count_d;
        line_count_q    <= '0;
        vsync_pending_q <= 1'b1;
        stable_count_q  <= stable_count_d;
        locked_q        <= (stable_count_d == LOCK_C);
        prev_height_q   <= line_count_d;
        prev_width_q    <= frame_width_d;
        irregular_q     <= 1'b0;
        have_line_q     <= 1'b0;
        timeout_q       <= '0;
      end else if (timeout_q[TIMEOUT_BITS]) begin
        stable_count_q  <= '0;
        locked_q        <= 1'b0;
        vsync_pending_q <= 1'b1;
        timeout_q       <= '0;
      end else begin
        timeout_q <= timeout_q + TONE_C;
      end
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign width       = width_q;
  assign height      = height_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_tmds_video_timing.sv
// tb/tb_tmds_video_timing.sv - randomized frame stimulus against a run/frame level reference model
module tb_tmds_video_timing;

  localparam int CB   = 12;
  localparam int MINR = 8;
  localparam int LF   = 3;
  localparam int TB   = 8;

  logic          hdmi_clk = 1'b0;
  logic          reset = 1'b0;
  logic          data_valid = 1'b0;
  logic          sync_valid = 1'b0;
  logic [1:0]    sync = 2'b00;
  logic [7:0]    d0 = '0, d1 = '0, d2 = '0;
  logic          pixel_valid, frame_start, line_start, locked;
  logic [7:0]    r, g, b;
  logic [CB-1:0] x, y, width, height;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: committed lines so far, pending new frame, frame history for lock
  int m_lines, m_pending, m_width, m_height, m_prevh, m_prevw;
  int m_stable, m_fw, m_have, m_irr, m_run, m_runy;
  bit m_vs;
  bit hs = 1'b0;

  tmds_video_timing #(
    .COORD_BITS(CB), .MIN_RUN(MINR), .VSYNC_POL(1'b1),
    .LOCK_FRAMES(LF), .TIMEOUT_BITS(TB)
  ) dut (
    .hdmi_clk(hdmi_clk), .reset(reset), .data_valid(data_valid),
    .sync_valid(sync_valid), .sync(sync), .d0(d0), .d1(d1), .d2(d2),
    .pixel_valid(pixel_valid), .r(r), .g(g), .b(b), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start),
    .width(width), .height(height), .locked(locked)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hdmi_clk);
    #1;
  endtask

  task automatic model_reset();
    m_lines = 0; m_pending = 0; m_width = 0; m_height = 0; m_prevh = 0; m_prevw = 0;
    m_stable = 0; m_fw = 0; m_have = 0; m_irr = 0; m_run = 0; m_runy = 0; m_vs = 1'b0;
  endtask

  task automatic model_end_run();
    if (m_run > 0) begin
      if (m_run >= MINR) begin
        m_width   = m_run;
        m_lines   = m_runy + 1;
        m_pending = 0;
        if (m_have == 0) begin
          m_fw   = m_run;
          m_have = 1;
        end else if (m_run != m_fw) begin
          m_irr = 1;
        end
      end
      m_run = 0;
    end
  endtask

  task automatic model_vsync();
    bit ok;
    ok = (m_irr == 0) && (m_lines != 0) && (m_lines == m_prevh) && (m_fw == m_prevw);
    m_height  = m_lines;
    m_stable  = ok ? ((m_stable < LF) ? m_stable + 1 : LF) : 0;
    m_prevh   = m_lines;
    m_prevw   = m_fw;
    m_irr     = 0;
    m_have    = 0;
    m_lines   = 0;
    m_pending = 1;
  endtask

  task automatic check_status();
    chk("width", 32'(width), m_width);
    chk("height", 32'(height), m_height);
    chk("locked", 32'(locked), 32'(m_stable == LF));
  endtask

  task automatic send_run(input int len);
    int yexp;
    int fs;
    logic [23:0] rgb;
    yexp = (m_pending != 0) ? 0 : m_lines;
    fs   = m_pending;
    for (int i = 0; i < len; i++) begin
      rgb = 24'($urandom);
      data_valid = 1'b1; sync_valid = 1'b0;
      {d2, d1, d0} = rgb;
      step();
      chk("pixel_valid", 32'(pixel_valid), 1);
      chk("x", 32'(x), i);
      chk("y", 32'(y), yexp);
      chk("rgb", 32'({r, g, b}), 32'(rgb));
      chk("line_start", 32'(line_start), 32'(i == 0));
      chk("frame_start", 32'(frame_start), 32'((i == 0) && (fs != 0)));
    end
    m_run  = len;
    m_runy = yexp;
  endtask

  task automatic send_sync(input int n, input bit vs);
    for (int k = 0; k < n; k++) begin
      hs = ~hs;
      data_valid = 1'b0; sync_valid = 1'b1; sync = {vs, hs};
      {d2, d1, d0} = 24'($urandom);
      model_end_run();
      if (!m_vs && vs) model_vsync();
      m_vs = vs;
      step();
      chk("blank_pixel_valid", 32'(pixel_valid), 0);
      chk("blank_line_start", 32'(line_start), 0);
      chk("blank_frame_start", 32'(frame_start), 0);
    end
  endtask

  task automatic send_vsync();
    send_sync(2, 1'b1);
    send_sync(1, 1'b0);
    check_status();
  endtask

  task automatic send_frame(input int h, input int w, input int odd_line, input int odd_w);
    for (int l = 0; l < h; l++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_run(2);
        send_sync(1, 1'b0);
      end
      send_run((l == odd_line) ? odd_w : w);
      send_sync(2, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_rgb"}, 32'({r, g, b}), 0);
    chk({tag, "_xy"}, 32'({x, y}), 0);
    chk({tag, "_width"}, 32'(width), 0);
    chk({tag, "_height"}, 32'(height), 0);
    chk({tag, "_strobes"}, 32'({frame_start, line_start}), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
  endtask

  initial begin
    int w, h;
    model_reset();
    #2 reset = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;

    w = $urandom_range(MINR + 2, MINR + 8);
    h = $urandom_range(4, 6);

    // free-running lines with no vsync seen yet
    for (int i = 0; i < 3; i++) begin
      send_run(w);
      send_sync(3, 1'b0);
    end
    check_status();
    chk("width_free_run", 32'(width), w);
    chk("locked_free_run", 32'(locked), 0);
    send_vsync();
    chk("height_free_run", 32'(height), 3);

    // four identical frames bring lock up
    for (int f = 0; f < 4; f++) begin
      send_frame(h, w, -1, 0);
      send_vsync();
      if (f == 2) chk("locked_after_3", 32'(locked), 0);
    end
    chk("locked_after_4", 32'(locked), 1);
    chk("height_frame", 32'(height), h);
    chk("width_frame", 32'(width), w);

    // one short frame drops lock
    send_frame(h - 1, w, -1, 0);
    send_vsync();
    chk("locked_short_frame", 32'(locked), 0);
    chk("height_short_frame", 32'(height), h - 1);

    for (int f = 0; f < 4; f++) begin
      send_frame(h, w, -1, 0);
      send_vsync();
    end
    chk("locked_relock", 32'(locked), 1);

    // one wide line makes the frame irregular
    send_frame(h, w, 2, w + 1);
    send_vsync();
    chk("locked_irregular", 32'(locked), 0);

    for (int f = 0; f < 3; f++) begin
      send_frame(h, w, -1, 0);
      send_vsync();
    end
    chk("locked_before_timeout", 32'(locked), 1);

    // constant vsync long enough to expire the timeout once
    send_sync(300, 1'b0);
    m_stable  = 0;
    m_pending = 1;
    check_status();
    chk("locked_timeout", 32'(locked), 0);
    send_run(w);
    send_sync(2, 1'b0);

    // reset in the middle of a run clears outputs without waiting for a clock
    for (int i = 0; i < 5; i++) begin
      data_valid = 1'b1; sync_valid = 1'b0;
      {d2, d1, d0} = 24'($urandom);
      step();
    end
    chk("midline_pixel_valid_pre", 32'(pixel_valid), 1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midline_reset");
    data_valid = 1'b0;
    model_reset();
    step();
    reset = 1'b0;
    send_run(w);
    send_sync(2, 1'b0);
    check_status();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
